ring_sequence_monitor: RTL and testbench
========================================

# ring_sequence_monitor

Supervisor that sits directly downstream of the 4-bit one-hot ring counter. It samples the ring outputs, checks that every step is a legal one-hot left rotation, and counts completed rotations. It drives the ring counter's active-low override input to force a resync after reset or on any corruption, and reports lock, phase and fault status to the rest of the design.

## Interface
- WIDTH, 4: ring width in bits (≥2).
- LOCK_ROT, 2: consecutive clean rotations needed to declare lock (≥1).
- CNT_W, 16: width of the rotation counter.
- CLK  in  1  system clock; the monitor uses the rising edge, and the ring counter updates on the falling edge.
- RST_N  in  1  reset, asynchronous, active-low.
- Q_IN  in  WIDTH  ring counter outputs.
- CLR  in  1  synchronous clear of ROT_CNT and ERR_CNT.
- OVERRIDE_OUT  out  1  active-low; wired to the ring counter's override input.
- LOCKED  out  1  ring verified and in lock.
- FAULT  out  1  one-cycle pulse on a bad step while in ACQUIRE or LOCKED.
- PHASE  out  $clog2(WIDTH)  index of the set bit of the last legal sample.
- ROT_CNT  out  CNT_W  completed rotations while LOCKED; wraps modulo 2^CNT_W.
- ERR_CNT  out  8  bad steps; saturates at 255.

## Operation
- State machine states: RESYNC, ACQUIRE, LOCKED. All outputs and state are registered.
- Reset values:
  - state = RESYNC
  - OVERRIDE_OUT = 0
  - LOCKED = 0, FAULT = 0
  - PHASE = 0, ROT_CNT = 0, ERR_CNT = 0
  - prev = 1 (bit 0 set)
  - good_rot = 0
- Step checks, made on each rising edge in ACQUIRE or LOCKED:
  - good step: Q_IN == rotl(prev, 1).
  - bad step: anything else, including all-zero and multi-hot values.
  - rotation: a good step where Q_IN == 1 and prev == 1<<(WIDTH-1).
- RESYNC:
  - OVERRIDE_OUT = 0 for exactly one rising-edge period.
  - On the next edge: go to ACQUIRE, set OVERRIDE_OUT = 1, prev = 1, PHASE = 0, good_rot = 0.
  - Q_IN is not checked in this state.
- ACQUIRE:
  - Good step: prev = Q_IN; PHASE = index of Q_IN.
  - Rotation: good_rot increments. When good_rot reaches LOCK_ROT, go to LOCKED and set LOCKED = 1.
  - Bad step: FAULT = 1, ERR_CNT + 1, go to RESYNC, OVERRIDE_OUT = 0.
- LOCKED:
  - Good step: update prev and PHASE as in ACQUIRE.
  - Rotation: ROT_CNT + 1.
  - Bad step: FAULT = 1, ERR_CNT + 1, LOCKED = 0, OVERRIDE_OUT = 0, go to RESYNC.
- Bad steps leave PHASE holding its last legal value.
- CLR has priority over a simultaneous increment: both counters read 0 on the next cycle. CLR does not affect state, LOCKED or PHASE.
- ERR_CNT at 255 stays at 255; FAULT still pulses.
- Reset asserted mid-operation: all state returns to reset values asynchronously. OVERRIDE_OUT low also holds the ring counter at value 1 on every falling edge.

## Timing
- Edge t0 is the first rising edge after RST_N deasserts. The state is RESYNC with OVERRIDE_OUT low.
- The ring loads 1 on the falling edge after t0.
- At t1 the monitor leaves RESYNC and OVERRIDE_OUT rises.
- Samples taken at t2 through t5 must be 0010, 0100, 1000, 0001. The t5 sample completes rotation 1.
- With LOCK_ROT = 2, rotation 2 completes at t9 and LOCKED reads 1 after t9.
- The first ROT_CNT increment occurs at t13.
- Fault-to-override latency is 1 cycle. Fault to the next good sample is 2 cycles: RESYNC, then exit.

## Structure
- Shared package ring_pkg:
  - state enum ring_mon_state_t {RESYNC, ACQUIRE, LOCKED}
  - RING_WIDTH_DEFAULT = 4
  - ERR_CNT_W = 8
- Sub-module ring_onehot_decode: combinational. Inputs are Q_IN and prev; outputs are good_step, rotation and idx.

## Test plan
- Connect the real 4-bit ring counter; release reset at t0 → OVERRIDE_OUT rises at t1, LOCKED = 1 after t9, ROT_CNT = 1 after t13, PHASE cycles 0→1→2→3.
- Drive Q_IN directly: 0001, 0010, then 0110 while LOCKED → FAULT pulses for one cycle, ERR_CNT = 1, LOCKED = 0, OVERRIDE_OUT low for one cycle, PHASE holds 1.
- Inject Q_IN = 0000 during ACQUIRE → FAULT = 1, state returns to RESYNC, LOCKED never asserts.
- Assert CLR in the same cycle as a bad step → ERR_CNT = 0 next cycle; FAULT still pulses.
- Force 300 bad steps → ERR_CNT saturates at 255.
- Set CNT_W = 2 and run 5 locked rotations → ROT_CNT = 1 (wrap). Assert RST_N low mid-rotation → all outputs at reset values immediately.

Source files
------------

// File: rtl/ring_pkg.sv
// Shared types and constants for the one-hot ring supervisor.
package ring_pkg;

  typedef enum logic [1:0] {
    RESYNC,
    ACQUIRE,
    LOCKED
  } ring_mon_state_t;

  localparam int RING_WIDTH_DEFAULT = 4;
  localparam int ERR_CNT_W          = 8;
  localparam logic [ERR_CNT_W-1:0] ERR_CNT_MAX = '1;

endpackage

// File: rtl/ring_onehot_decode.sv
// Classifies one ring sample against the previous legal sample: legal step,
// wrap-around (completed rotation), and bit index of the sample.
module ring_onehot_decode
  import ring_pkg::*;
#(
  parameter  int WIDTH = RING_WIDTH_DEFAULT,
  localparam int IDX_W = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] q_i,
  input  logic [WIDTH-1:0] prev_i,
  output logic             good_step_o,
  output logic             rotation_o,
  output logic [IDX_W-1:0] idx_o
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);
  localparam logic [WIDTH-1:0] MSB = ONE << (WIDTH - 1);

  logic [WIDTH-1:0] expected;

  assign expected    = {prev_i[WIDTH-2:0], prev_i[WIDTH-1]};
  assign good_step_o = (q_i == expected);
  assign rotation_o  = good_step_o && (q_i == ONE) && (prev_i == MSB);

  // Only meaningful for one-hot samples; callers use it on good steps only.
  always_comb begin
    idx_o = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (q_i[i]) idx_o = IDX_W'(i);
    end
  end

endmodule

// File: rtl/ring_sequence_monitor.sv
// Supervisor for a one-hot ring counter: verifies every step, forces resync
// through the ring's active-low override, and counts rotations and faults.
module ring_sequence_monitor
  import ring_pkg::*;
#(
  parameter  int WIDTH    = RING_WIDTH_DEFAULT,
  parameter  int LOCK_ROT = 2,
  parameter  int CNT_W    = 16,
  localparam int PH_W     = $clog2(WIDTH)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [WIDTH-1:0]     q_in,
  input  logic                 clr,
  output logic                 override_out,
  output logic                 locked,
  output logic                 fault,
  output logic [PH_W-1:0]      phase,
  output logic [CNT_W-1:0]     rot_cnt,
  output logic [ERR_CNT_W-1:0] err_cnt
);

  localparam int               GR_W = $clog2(LOCK_ROT + 1);
  localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);

  ring_mon_state_t      state_q;
  logic [WIDTH-1:0]     prev_q;
  logic [GR_W-1:0]      good_rot_q;
  logic                 boot_q;
  logic                 override_q;
  logic                 locked_q;
  logic                 fault_q;
  logic [PH_W-1:0]      phase_q;
  logic [CNT_W-1:0]     rot_cnt_q, rot_cnt_d;
  logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;

  logic            good_step;
  logic            rotation;
  logic [PH_W-1:0] idx;
  logic            checking;
  logic            bad_step;
  logic            rot_event;

  ring_onehot_decode #(
    .WIDTH (WIDTH)
  ) u_decode (
    .q_i         (q_in),
    .prev_i      (prev_q),
    .good_step_o (good_step),
    .rotation_o  (rotation),
    .idx_o       (idx)
  );

  assign checking  = (state_q != RESYNC);
  assign bad_step  = checking && !good_step;
  assign rot_event = (state_q == LOCKED) && rotation;

  // NOTE: every variable gets a default before any condition, so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    rot_cnt_d = rot_cnt_q;
    err_cnt_d = err_cnt_q;
    if (clr) begin
      rot_cnt_d = '0;
      err_cnt_d = '0;
    end else begin
      if (rot_event) rot_cnt_d = rot_cnt_q + CNT_W'(1);
      if (bad_step && (err_cnt_q != ERR_CNT_MAX)) err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
    end
  end

  // boot_q stretches the post-reset RESYNC by one edge so the ring has a
  // falling edge with override low before the first checked sample.
  // NOTE: non-blocking assignments throughout, so every register updates
  // from pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= RESYNC;
      prev_q     <= ONE;
      good_rot_q <= '0;
      boot_q     <= 1'b1;
      override_q <= 1'b0;
      locked_q   <= 1'b0;
      fault_q    <= 1'b0;
      phase_q    <= '0;
      rot_cnt_q  <= '0;
      err_cnt_q  <= '0;
    end else begin
      fault_q   <= 1'b0;
      rot_cnt_q <= rot_cnt_d;
      err_cnt_q <= err_cnt_d;
      unique case (state_q)
        RESYNC: begin
          if (boot_q) begin
            boot_q <= 1'b0;
          end else begin
            state_q    <= ACQUIRE;
            override_q <= 1'b1;
            prev_q     <= ONE;
            phase_q    <= '0;
            good_rot_q <= '0;
          end
        end
        ACQUIRE, LOCKED: begin
          if (good_step) begin
            prev_q  <= q_in;
            phase_q <= idx;
            if (rotation && (state_q == ACQUIRE)) begin
              good_rot_q <= good_rot_q + GR_W'(1);
              if (good_rot_q == GR_W'(LOCK_ROT - 1)) begin
                state_q  <= LOCKED;
                locked_q <= 1'b1;
              end
            end
          end else begin
            fault_q    <= 1'b1;
            locked_q   <= 1'b0;
            override_q <= 1'b0;
            state_q    <= RESYNC;
          end
        end
        default: begin
          state_q    <= RESYNC;
          override_q <= 1'b0;
          locked_q   <= 1'b0;
        end
      endcase
    end
  end

  assign override_out = override_q;
  assign locked       = locked_q;
  assign fault        = fault_q;
  assign phase        = phase_q;
  assign rot_cnt      = rot_cnt_q;
  assign err_cnt      = err_cnt_q;

endmodule

// File: tb/tb_ring_sequence_monitor.sv
// Bench for ring_sequence_monitor: a falling-edge ring counter model drives
// two monitors (16-bit and 2-bit rotation counters) checked against a rule model.
module tb_ring_sequence_monitor;

  localparam int LR = 2;
  localparam int M_RESYNC = 0;
  localparam int M_ACQ    = 1;
  localparam int M_LOCK   = 2;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       clr   = 1'b0;
  logic [3:0] q_in  = 4'b0001;

  logic        o16_ovr, o16_lock, o16_fault;
  logic [1:0]  o16_phase;
  logic [15:0] o16_rot;
  logic [7:0]  o16_err;
  logic        o2_ovr, o2_lock, o2_fault;
  logic [1:0]  o2_phase;
  logic [1:0]  o2_rot;
  logic [7:0]  o2_err;

  int vectors     = 0;
  int miscompares = 0;

  ring_sequence_monitor #(.WIDTH(4), .LOCK_ROT(LR), .CNT_W(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .q_in(q_in), .clr(clr),
    .override_out(o16_ovr), .locked(o16_lock), .fault(o16_fault),
    .phase(o16_phase), .rot_cnt(o16_rot), .err_cnt(o16_err)
  );

  ring_sequence_monitor #(.WIDTH(4), .LOCK_ROT(LR), .CNT_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .q_in(q_in), .clr(clr),
    .override_out(o2_ovr), .locked(o2_lock), .fault(o2_fault),
    .phase(o2_phase), .rot_cnt(o2_rot), .err_cnt(o2_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the monitor's rules applied to each sampled value.
  int         m_mode   = M_RESYNC;
  bit         m_boot   = 1'b1;
  logic [3:0] m_prev   = 4'b0001;
  int         m_good   = 0;
  bit         m_ovr    = 1'b0;
  bit         m_locked = 1'b0;
  bit         m_fault  = 1'b0;
  int         m_phase  = 0;
  int         m_rot    = 0;
  int         m_err    = 0;
  bit         m_bad, m_rotev;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_mode = M_RESYNC; m_boot = 1'b1; m_prev = 4'b0001; m_good = 0;
      m_ovr = 1'b0; m_locked = 1'b0; m_fault = 1'b0;
      m_phase = 0; m_rot = 0; m_err = 0;
    end else begin
      m_fault = 1'b0;
      m_bad   = 1'b0;
      m_rotev = 1'b0;
      if (m_mode == M_RESYNC) begin
        if (m_boot) m_boot = 1'b0;
        else begin
          m_mode = M_ACQ; m_ovr = 1'b1; m_prev = 4'b0001; m_phase = 0; m_good = 0;
        end
      end else if (q_in == {m_prev[2:0], m_prev[3]}) begin
        if (q_in == 4'b0001 && m_prev == 4'b1000) begin
          if (m_mode == M_LOCK) m_rotev = 1'b1;
          else m_good++;
        end
        m_prev  = q_in;
        m_phase = $clog2(q_in);
        if (m_mode == M_ACQ && m_good == LR) begin
          m_mode = M_LOCK; m_locked = 1'b1;
        end
      end else begin
        m_fault = 1'b1; m_bad = 1'b1; m_mode = M_RESYNC; m_ovr = 1'b0; m_locked = 1'b0;
      end
      if (clr) begin
        m_rot = 0; m_err = 0;
      end else begin
        if (m_rotev) m_rot++;
        if (m_bad && m_err < 255) m_err++;
      end
    end
  end

  always @(posedge clk) begin
    #1;
    check("ovr16",   o16_ovr,   m_ovr);
    check("lock16",  o16_lock,  m_locked);
    check("fault16", o16_fault, m_fault);
    check("phase16", o16_phase, m_phase);
    check("rot16",   o16_rot,   m_rot % 65536);
    check("err16",   o16_err,   m_err);
    check("ovr2",    o2_ovr,    m_ovr);
    check("lock2",   o2_lock,   m_locked);
    check("fault2",  o2_fault,  m_fault);
    check("rot2",    o2_rot,    m_rot % 4);
    check("err2",    o2_err,    m_err);
  end

  // Ring counter: updates on the falling edge, loads 1 while override is low.
  task automatic ring_step();
    @(negedge clk);
    clr  = 1'b0;
    q_in = o16_ovr ? {q_in[2:0], q_in[3]} : 4'b0001;
  endtask

  task automatic drive(input logic [3:0] v, input logic c);
    @(negedge clk);
    q_in = v;
    clr  = c;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ovr"},   o16_ovr,   0);
    check({tag, "_lock"},  o16_lock,  0);
    check({tag, "_fault"}, o16_fault, 0);
    check({tag, "_phase"}, o16_phase, 0);
    check({tag, "_rot"},   o16_rot,   0);
    check({tag, "_err"},   o16_err,   0);
    check({tag, "_rot2"},  o2_rot,    0);
    check({tag, "_err2"},  o2_err,    0);
  endtask

  logic [1:0] ph_exp [4] = '{2'd1, 2'd2, 2'd3, 2'd0};
  logic [3:0] bad_v;

  initial begin
    repeat (3) ring_step();
    #1;
    check_reset_outputs("rst");
    ring_step();
    rst_n = 1'b1;

    // Boot timeline: t0 is the first rising edge after release.
    for (int t = 0; t <= 30; t++) begin
      @(posedge clk);
      #1;
      if (t == 0)  check("t0_ovr", o16_ovr, 0);
      if (t == 1)  check("t1_ovr", o16_ovr, 1);
      if (t >= 2 && t <= 5) check("boot_phase", o16_phase, ph_exp[t-2]);
      if (t == 8)  check("t8_lock", o16_lock, 0);
      if (t == 9)  check("t9_lock", o16_lock, 1);
      if (t == 12) check("t12_rot", o16_rot, 0);
      if (t == 13) check("t13_rot", o16_rot, 1);
      if (t == 29) begin
        check("t29_rot16", o16_rot, 5);
        check("t29_rot2_wrap", o2_rot, 1);
      end
      ring_step();
    end

    // Corrupt a locked ring: 0001, 0010, then multi-hot 0110.
    for (int k = 0; k < 8 && q_in != 4'b1000; k++) ring_step();
    drive(4'b0001, 1'b0);
    drive(4'b0010, 1'b0);
    drive(4'b0110, 1'b0);
    @(posedge clk); #1;
    check("mh_fault", o16_fault, 1);
    check("mh_lock",  o16_lock,  0);
    check("mh_ovr",   o16_ovr,   0);
    check("mh_phase", o16_phase, 1);
    check("mh_err",   o16_err,   1);
    ring_step();
    @(posedge clk); #1;
    check("mh_fault_pulse", o16_fault, 0);
    check("mh_ovr_back",    o16_ovr,   1);

    // All-zero sample during ACQUIRE.
    ring_step();
    ring_step();
    drive(4'b0000, 1'b0);
    @(posedge clk); #1;
    check("zero_fault", o16_fault, 1);
    check("zero_ovr",   o16_ovr,   0);
    check("zero_err",   o16_err,   2);
    for (int k = 0; k < 6; k++) begin
      ring_step();
      @(posedge clk); #1;
      check("zero_nolock", o16_lock, 0);
    end

    // CLR together with a bad step.
    drive(4'b1111, 1'b1);
    @(posedge clk); #1;
    check("clr_err",   o16_err,   0);
    check("clr_fault", o16_fault, 1);
    check("clr_rot",   o16_rot,   0);

    // 300 bad steps: every other edge is a checked sample.
    for (int k = 0; k < 600; k++) begin
      bad_v = 4'($urandom);
      if (bad_v == 4'b0010) bad_v = 4'b0110;
      drive(bad_v, 1'b0);
    end
    @(posedge clk); #1;
    check("sat_err16", o16_err, 255);
    check("sat_err2",  o2_err,  255);

    // Randomized operation with occasional corruption and clears.
    for (int k = 0; k < 3000; k++) begin
      @(negedge clk);
      clr = ($urandom_range(31) == 0);
      if ($urandom_range(15) == 0) q_in = 4'($urandom);
      else q_in = o16_ovr ? {q_in[2:0], q_in[3]} : 4'b0001;
    end

    // Clean run to lock, then asynchronous reset mid-rotation.
    repeat (20) ring_step();
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("async");
    repeat (3) ring_step();
    rst_n = 1'b1;
    repeat (20) ring_step();
    @(posedge clk); #1;
    check("final_lock", o16_lock, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
